// File: rtl/ram_arbiter_if.sv
// Requester and RAM-side signals of the data RAM arbiter.
// The master view is the arbiter; the slave view is the requesters plus the RAM.
interface ram_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) ();
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_w_data;
  logic              cpu_gnt;
  logic              cpu_r_valid;
  logic [DATA_W-1:0] cpu_r_data;

  logic              aux_req;
  logic              aux_we;
  logic [ADDR_W-1:0] aux_addr;
  logic [DATA_W-1:0] aux_w_data;
  logic              aux_gnt;
  logic              aux_r_valid;
  logic [DATA_W-1:0] aux_r_data;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_w_enable;
  logic [DATA_W-1:0] ram_w_data;
  logic [DATA_W-1:0] ram_r_data;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_w_data,
    output cpu_gnt, cpu_r_valid, cpu_r_data,
    input  aux_req, aux_we, aux_addr, aux_w_data,
    output aux_gnt, aux_r_valid, aux_r_data,
    output ram_addr, ram_w_enable, ram_w_data,
    input  ram_r_data
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_w_data,
    input  cpu_gnt, cpu_r_valid, cpu_r_data,
    output aux_req, aux_we, aux_addr, aux_w_data,
    input  aux_gnt, aux_r_valid, aux_r_data,
    input  ram_addr, ram_w_enable, ram_w_data,
    output ram_r_data
  );
endinterface

// File: rtl/ram_arbiter.sv
// Shares the single-port data RAM between the CPU path and an auxiliary master.
// The CPU has fixed priority; a saturating starvation counter forces an aux grant.
module ram_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 4
) (
  input logic          clk,
  input logic          rst,
  ram_arbiter_if.master bus
);

  localparam int              CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              cpu_pend_q, cpu_pend_d;
  logic              aux_pend_q, aux_pend_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, aux_rdata_q;

  logic cpu_gnt, aux_gnt, w_en;
  logic cpu_rvld, aux_rvld;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == LIMIT) ? v : v + 1'b1;
  endfunction

  // Grant decision and RAM-side mux; everything forced quiet while in reset.
  always_comb begin
    cpu_gnt = 1'b0;
    aux_gnt = 1'b0;
    if (!rst) begin
      if (bus.cpu_req && bus.aux_req) begin
        if (starve_q == LIMIT) aux_gnt = 1'b1;
        else                   cpu_gnt = 1'b1;
      end else if (bus.cpu_req) begin
        cpu_gnt = 1'b1;
      end else if (bus.aux_req) begin
        aux_gnt = 1'b1;
      end
    end

    addr_d  = addr_q;
    wdata_d = wdata_q;
    w_en    = 1'b0;
    if (rst) begin
      addr_d  = '0;
      wdata_d = '0;
    end else if (cpu_gnt) begin
      addr_d  = bus.cpu_addr;
      wdata_d = bus.cpu_w_data;
      w_en    = bus.cpu_we;
    end else if (aux_gnt) begin
      addr_d  = bus.aux_addr;
      wdata_d = bus.aux_w_data;
      w_en    = bus.aux_we;
    end

    cpu_pend_d = cpu_gnt & ~bus.cpu_we;
    aux_pend_d = aux_gnt & ~bus.aux_we;

    starve_d = starve_q;
    if (aux_gnt || !bus.aux_req) starve_d = '0;
    else if (cpu_gnt)            starve_d = sat_inc(starve_q);
  end

  assign cpu_rvld = cpu_pend_q & ~rst;
  assign aux_rvld = aux_pend_q & ~rst;

  assign bus.cpu_gnt      = cpu_gnt;
  assign bus.aux_gnt      = aux_gnt;
  assign bus.ram_addr     = addr_d;
  assign bus.ram_w_data   = wdata_d;
  assign bus.ram_w_enable = w_en;
  assign bus.cpu_r_valid  = cpu_rvld;
  assign bus.aux_r_valid  = aux_rvld;
  // Read data is bypassed in the valid cycle so it appears together with r_valid.
  assign bus.cpu_r_data   = rst ? '0 : (cpu_rvld ? bus.ram_r_data : cpu_rdata_q);
  assign bus.aux_r_data   = rst ? '0 : (aux_rvld ? bus.ram_r_data : aux_rdata_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q    <= '0;
      cpu_pend_q  <= 1'b0;
      aux_pend_q  <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      aux_rdata_q <= '0;
    end else begin
      starve_q   <= starve_d;
      cpu_pend_q <= cpu_pend_d;
      aux_pend_q <= aux_pend_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if (cpu_rvld) cpu_rdata_q <= bus.ram_r_data;
      if (aux_rvld) aux_rdata_q <= bus.ram_r_data;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 1-cycle synchronous RAM.
module tb_ram_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_asrt = 0;
  int   n_fail = 0;

  ram_arbiter_if #(.ADDR_W(12), .DATA_W(8)) bus ();

  ram_arbiter #(.ADDR_W(12), .DATA_W(8), .STARVE_LIMIT(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:4095];
  always @(posedge clk) begin
    if (bus.ram_w_enable) mem[bus.ram_addr] <= bus.ram_w_data;
    bus.ram_r_data <= mem[bus.ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic cr, input logic cw, input logic [11:0] ca, input logic [7:0] cd,
                     input logic ar, input logic aw, input logic [11:0] aa, input logic [7:0] ad);
    bus.cpu_req = cr; bus.cpu_we = cw; bus.cpu_addr = ca; bus.cpu_w_data = cd;
    bus.aux_req = ar; bus.aux_we = aw; bus.aux_addr = aa; bus.aux_w_data = ad;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic prev_c, prev_a, exp_a;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    bus.ram_r_data = 8'h00;
    drv(0, 0, 12'h000, 8'h00, 0, 0, 12'h000, 8'h00);

    // 1: reset holds everything quiet even with both requesting
    nxt(); drv(1, 1, 12'h555, 8'h5A, 1, 0, 12'h2AA, 8'h00); smp();
    chk("rst1_cpu_gnt", 32'(bus.cpu_gnt), 32'd0);
    chk("rst1_aux_gnt", 32'(bus.aux_gnt), 32'd0);
    chk("rst1_w_en", 32'(bus.ram_w_enable), 32'd0);
    chk("rst1_addr", 32'(bus.ram_addr), 32'h000);
    nxt(); smp();
    chk("rst2_cpu_gnt", 32'(bus.cpu_gnt), 32'd0);
    chk("rst2_aux_gnt", 32'(bus.aux_gnt), 32'd0);
    chk("rst2_w_en", 32'(bus.ram_w_enable), 32'd0);
    chk("rst2_addr", 32'(bus.ram_addr), 32'h000);
    chk("rst2_wdata", 32'(bus.ram_w_data), 32'h00);
    nxt(); rst = 1'b0; smp();
    chk("post_rst_cpu_gnt", 32'(bus.cpu_gnt), 32'd1);
    chk("post_rst_aux_gnt", 32'(bus.aux_gnt), 32'd0);
    chk("post_rst_addr", 32'(bus.ram_addr), 32'h555);

    // 2: CPU alone, write then read back
    nxt(); drv(1, 1, 12'h123, 8'hA5, 0, 0, 12'h000, 8'h00); smp();
    chk("t2_wr_gnt", 32'(bus.cpu_gnt), 32'd1);
    chk("t2_wr_we", 32'(bus.ram_w_enable), 32'd1);
    chk("t2_wr_addr", 32'(bus.ram_addr), 32'h123);
    chk("t2_wr_data", 32'(bus.ram_w_data), 32'hA5);
    nxt(); drv(1, 0, 12'h123, 8'h00, 0, 0, 12'h000, 8'h00); smp();
    chk("t2_rd_gnt", 32'(bus.cpu_gnt), 32'd1);
    chk("t2_rd_we", 32'(bus.ram_w_enable), 32'd0);
    chk("t2_rd_no_vld", 32'(bus.cpu_r_valid), 32'd0);
    nxt(); drv(0, 0, 12'h000, 8'h00, 0, 0, 12'h000, 8'h00); smp();
    chk("t2_cpu_rvld", 32'(bus.cpu_r_valid), 32'd1);
    chk("t2_cpu_rdata", 32'(bus.cpu_r_data), 32'hA5);
    chk("t2_aux_rvld", 32'(bus.aux_r_valid), 32'd0);
    chk("t2_idle_gnt", 32'(bus.cpu_gnt), 32'd0);
    chk("t2_addr_hold", 32'(bus.ram_addr), 32'h123);

    // 3: both reading continuously, aux gets every fifth slot
    prev_c = 1'b0; prev_a = 1'b0;
    for (int i = 0; i < 10; i++) begin
      nxt(); drv(1, 0, 12'h123, 8'h00, 1, 0, 12'h555, 8'h00); smp();
      exp_a = (i == 4) || (i == 9);
      chk($sformatf("t3_cpu_gnt_%0d", i), 32'(bus.cpu_gnt), 32'(!exp_a));
      chk($sformatf("t3_aux_gnt_%0d", i), 32'(bus.aux_gnt), 32'(exp_a));
      chk($sformatf("t3_cpu_rvld_%0d", i), 32'(bus.cpu_r_valid), 32'(prev_c));
      chk($sformatf("t3_aux_rvld_%0d", i), 32'(bus.aux_r_valid), 32'(prev_a));
      if (prev_a) chk($sformatf("t3_aux_rdata_%0d", i), 32'(bus.aux_r_data), 32'h5A);
      if (prev_c) chk($sformatf("t3_cpu_rdata_%0d", i), 32'(bus.cpu_r_data), 32'hA5);
      prev_c = !exp_a;
      prev_a = exp_a;
    end
    nxt(); drv(0, 0, 12'h000, 8'h00, 0, 0, 12'h000, 8'h00); smp();
    chk("t3_last_aux_rvld", 32'(bus.aux_r_valid), 32'd1);
    chk("t3_last_cpu_rvld", 32'(bus.cpu_r_valid), 32'd0);
    chk("t3_last_aux_rdata", 32'(bus.aux_r_data), 32'h5A);

    // 4: aux alone, write then read at top of memory
    nxt(); drv(0, 0, 12'h000, 8'h00, 1, 1, 12'hFFF, 8'h3C); smp();
    chk("t4_wr_gnt", 32'(bus.aux_gnt), 32'd1);
    chk("t4_wr_we", 32'(bus.ram_w_enable), 32'd1);
    chk("t4_wr_addr", 32'(bus.ram_addr), 32'hFFF);
    chk("t4_wr_data", 32'(bus.ram_w_data), 32'h3C);
    nxt(); drv(0, 0, 12'h000, 8'h00, 1, 0, 12'hFFF, 8'h00); smp();
    chk("t4_rd_gnt", 32'(bus.aux_gnt), 32'd1);
    chk("t4_rd_we", 32'(bus.ram_w_enable), 32'd0);
    nxt(); drv(0, 0, 12'h000, 8'h00, 0, 0, 12'h000, 8'h00); smp();
    chk("t4_aux_rvld", 32'(bus.aux_r_valid), 32'd1);
    chk("t4_aux_rdata", 32'(bus.aux_r_data), 32'h3C);
    chk("t4_cpu_rdata_kept", 32'(bus.cpu_r_data), 32'hA5);
    chk("t4_cpu_rvld", 32'(bus.cpu_r_valid), 32'd0);

    // 5: reset cancels an outstanding CPU read
    nxt(); drv(1, 0, 12'h010, 8'h00, 1, 0, 12'hFFF, 8'h00); smp();
    chk("t5_cpu_gnt", 32'(bus.cpu_gnt), 32'd1);
    nxt(); rst = 1'b1; drv(0, 0, 12'h000, 8'h00, 0, 0, 12'h000, 8'h00); smp();
    chk("t5_rst_cpu_rvld", 32'(bus.cpu_r_valid), 32'd0);
    chk("t5_rst_starve_pre", 32'(dut.starve_q), 32'd1);
    chk("t5_rst_addr", 32'(bus.ram_addr), 32'h000);
    nxt(); rst = 1'b0; smp();
    chk("t5_after_cpu_rvld", 32'(bus.cpu_r_valid), 32'd0);
    chk("t5_after_aux_rvld", 32'(bus.aux_r_valid), 32'd0);
    chk("t5_after_starve", 32'(dut.starve_q), 32'd0);
    chk("t5_after_cpu_rdata", 32'(bus.cpu_r_data), 32'h00);

    // 6: aux drop clears the starvation count
    for (int i = 0; i < 3; i++) begin
      nxt(); drv(1, 0, 12'h123, 8'h00, 1, 0, 12'h555, 8'h00); smp();
      chk($sformatf("t6_pre_cpu_gnt_%0d", i), 32'(bus.cpu_gnt), 32'd1);
    end
    chk("t6_starve_3", 32'(dut.starve_q), 32'd2);
    nxt(); drv(1, 0, 12'h123, 8'h00, 0, 0, 12'h555, 8'h00); smp();
    chk("t6_drop_cpu_gnt", 32'(bus.cpu_gnt), 32'd1);
    for (int i = 0; i < 4; i++) begin
      nxt(); drv(1, 0, 12'h123, 8'h00, 1, 0, 12'h555, 8'h00); smp();
      if (i == 0) chk("t6_starve_cleared", 32'(dut.starve_q), 32'd0);
      chk($sformatf("t6_cpu_gnt_%0d", i), 32'(bus.cpu_gnt), 32'd1);
      chk($sformatf("t6_aux_wait_%0d", i), 32'(bus.aux_gnt), 32'd0);
    end
    nxt(); smp();
    chk("t6_aux_gnt", 32'(bus.aux_gnt), 32'd1);
    chk("t6_cpu_no_gnt", 32'(bus.cpu_gnt), 32'd0);

    // 7: CPU write followed by aux read of the same address
    nxt(); drv(1, 1, 12'h200, 8'h77, 0, 0, 12'h000, 8'h00); smp();
    chk("t7_cpu_wr_gnt", 32'(bus.cpu_gnt), 32'd1);
    nxt(); drv(0, 0, 12'h000, 8'h00, 1, 0, 12'h200, 8'h00); smp();
    chk("t7_aux_rd_gnt", 32'(bus.aux_gnt), 32'd1);
    nxt(); drv(0, 0, 12'h000, 8'h00, 0, 0, 12'h000, 8'h00); smp();
    chk("t7_aux_rvld", 32'(bus.aux_r_valid), 32'd1);
    chk("t7_aux_rdata", 32'(bus.aux_r_data), 32'h77);
    nxt(); smp();
    chk("t7_aux_rvld_once", 32'(bus.aux_r_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-requester arbiter that shares the single-port data RAM (12-bit address, 8-bit data, 1-cycle synchronous read) between the CPU decoder path and an auxiliary master, such as a loader or DMA engine.
- Sits between the requesters and the ram instance; the RAM's ports are driven only by this block.
- Fixed priority goes to the CPU, with a starvation counter that forces an aux grant after a bounded number of lost arbitrations.

Parameters:
- ADDR_W, 12, RAM address width.
- DATA_W, 8, RAM data width.
- STARVE_LIMIT, 4, number of consecutive CPU grants allowed while aux is waiting (legal range 1..15).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- cpu_req  input  1  CPU access request, level
- cpu_we  input  1  1 = write, 0 = read
- cpu_addr  input  ADDR_W  CPU address
- cpu_w_data  input  DATA_W  CPU write data
- cpu_gnt  output  1  CPU access issued this cycle
- cpu_r_valid  output  1  CPU read data valid
- cpu_r_data  output  DATA_W  CPU read data
- aux_req  input  1  aux access request, level
- aux_we  input  1  1 = write, 0 = read
- aux_addr  input  ADDR_W  aux address
- aux_w_data  input  DATA_W  aux write data
- aux_gnt  output  1  aux access issued this cycle
- aux_r_valid  output  1  aux read data valid
- aux_r_data  output  DATA_W  aux read data
- ram_addr  output  ADDR_W  to ram addr
- ram_w_enable  output  1  to ram w_enable
- ram_w_data  output  DATA_W  to ram w_data
- ram_r_data  input  DATA_W  from ram r_data, valid 1 cycle after the address is presented

Behaviour:
- Reset: while rst=1, the following are all 0 combinationally and on the next edge:
  - cpu_gnt, aux_gnt, cpu_r_valid, aux_r_valid, ram_w_enable
  - ram_addr, ram_w_data
  - the starvation counter and the pending-read flags
- Reset during an outstanding read cancels that read; no r_valid is ever produced for it.
- Grant decision is combinational within the cycle, and at most one grant is issued per cycle:
  - Only cpu_req → cpu_gnt=1.
  - Only aux_req → aux_gnt=1.
  - Both, and starve_cnt < STARVE_LIMIT → cpu_gnt=1.
  - Both, and starve_cnt == STARVE_LIMIT → aux_gnt=1.
  - Neither → no grant.
- Handshake:
  - A request is consumed in the cycle its gnt=1.
  - The requester holds req, we, addr and w_data stable until it sees gnt.
  - A requester keeping req high after gnt is treated as a new request in the next cycle (back-to-back accesses allowed, 1 per cycle).
- RAM drive:
  - ram_addr and ram_w_data are muxed from the granted requester.
  - ram_w_enable = granted requester's we.
  - With no grant: ram_w_enable=0, and ram_addr and ram_w_data hold their last driven values (registered copy).
- Read return:
  - A granted read (we=0) sets a pending flag tagged with the owner.
  - Next cycle, the owner's r_valid is high for exactly 1 cycle.
  - Writes never produce r_valid.
- Read data:
  - cpu_r_data and aux_r_data are held registers, loaded from ram_r_data in the owner's r_valid cycle (combinational bypass in that cycle, so the value is visible with valid).
  - They keep the value until that owner's next r_valid.
  - Reset value is 0.
- Starvation counter (width ceil(log2(STARVE_LIMIT+1))):
  - Increments when cpu_gnt=1 and aux_req=1, saturating at STARVE_LIMIT.
  - Clears when aux_gnt=1 or aux_req=0.
- Simultaneous events:
  - A write by one owner followed by a read by the other at the same address on the next cycle returns the new data (RAM ordering, no bypass needed).
  - Arbitration and read return overlap freely: a new grant may issue in the same cycle as the previous access's r_valid.

Test Plan:
1. Reset with cpu_req=aux_req=1, cpu_we=1 for 2 cycles → cpu_gnt=aux_gnt=0, ram_w_enable=0, ram_addr=0x000 in both cycles. The first grant appears in the cycle after rst falls.
2. CPU alone: write 0x123←0xA5, then read 0x123 next cycle.
   - Write cycle: cpu_gnt=1, ram_w_enable=1, ram_addr=0x123, ram_w_data=0xA5.
   - Read cycle: cpu_gnt=1, ram_w_enable=0.
   - Cycle after the read: cpu_r_valid=1 with cpu_r_data=0xA5. aux_r_valid stays 0 throughout.
3. Both request continuously (reads) with STARVE_LIMIT=4 → grant sequence C,C,C,C,A,C,C,C,C,A. Each aux grant is followed 1 cycle later by aux_r_valid=1 only.
4. Aux alone writes 0xFFF←0x3C, then reads 0xFFF → aux_r_valid=1 with aux_r_data=0x3C. cpu_r_data keeps its previous value.
5. CPU read granted at 0x010, rst=1 in the next cycle → cpu_r_valid=0 in that cycle and afterwards; the starvation counter reads 0 after reset.
6. Both requesting, aux_req dropped for 1 cycle after 3 CPU grants, then reasserted → counter clears; aux waits 4 further CPU grants before aux_gnt=1.
